// File: rtl/toll_pkg.sv
// toll_pkg: shared lane state encoding and E-pass code helpers for the toll gate array.
package toll_pkg;
   typedef enum logic [1:0] {IDLE = 2'b00, MEASURE = 2'b01, VALIDATE = 2'b10, OPEN = 2'b11} lane_state_t;
   localparam logic [1:0] EPASS_ACCEPT = 2'b10;
   localparam logic [1:0] EPASS_REJECT = 2'b01;
   function automatic logic epass_pending(input logic [1:0] code);
      return code == 2'b00 || code == 2'b11;
   endfunction
endpackage

// File: rtl/toll_lane_fsm.sv
// toll_lane_fsm: one entry lane -- transit timing, E-pass validation with timeout, barrier control.
module toll_lane_fsm
   import toll_pkg::*;
#(
   parameter int TIME_W  = 8,
   parameter int TIMEOUT = 200
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              grant,
   input  logic              s_mid,
   input  logic              s_exit,
   input  logic [1:0]        epass,
   output logic              calc_req,
   output logic [TIME_W-1:0] transit_time,
   output logic              gate_up,
   output logic              reject,
   output logic              arrival,
   output logic              busy
);
   localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);
   lane_state_t state, state_nx;
   logic [TIME_W-1:0] timer, timer_nx, transit_nx;
   logic [15:0] wait_cnt, wait_nx;
   logic exit_prev, calc_nx, reject_nx;
   assign gate_up = state == OPEN;
   assign busy = state != IDLE;
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         state        <= IDLE;
         timer        <= '0;
         wait_cnt     <= '0;
         transit_time <= '0;
         calc_req     <= 1'b0;
         reject       <= 1'b0;
         exit_prev    <= 1'b0;
      end else begin
         state        <= state_nx;
         timer        <= timer_nx;
         wait_cnt     <= wait_nx;
         transit_time <= transit_nx;
         calc_req     <= calc_nx;
         reject       <= reject_nx;
         exit_prev    <= s_exit;
      end
   // arrival is combinational so occupancy counts the car on the same edge its reservation is released
   always_comb begin
      state_nx   = state;
      timer_nx   = timer;
      wait_nx    = wait_cnt;
      transit_nx = transit_time;
      calc_nx    = 1'b0;
      reject_nx  = 1'b0;
      arrival    = 1'b0;
      case (state)
         IDLE:
            if (grant) begin
               state_nx = MEASURE;
               timer_nx = '0;
            end
         MEASURE:
            if (s_mid) begin
               state_nx   = VALIDATE;
               transit_nx = timer;
               calc_nx    = 1'b1;
               wait_nx    = '0;
            end else if (timer != '1) timer_nx = timer + 1'b1;
         VALIDATE:
            if (epass == EPASS_ACCEPT) state_nx = OPEN;
            else if (!epass_pending(epass) || wait_cnt == WAIT_LAST) begin
               state_nx  = IDLE;
               reject_nx = 1'b1;
            end else wait_nx = wait_cnt + 1'b1;
         OPEN:
            if (exit_prev && !s_exit) begin
               state_nx = IDLE;
               arrival  = 1'b1;
            end
         default: state_nx = IDLE;
      endcase
   end
endmodule

// File: rtl/toll_gate_array_ctrl.sv
// toll_gate_array_ctrl: multi-lane toll gate controller with admission arbitration against
// a shared, saturating lot-occupancy counter that reserves space for cars already in a lane.
module toll_gate_array_ctrl
   import toll_pkg::*;
#(
   parameter int NUM_LANES = 2,
   parameter int TIME_W    = 8,
   parameter int TIMEOUT   = 200,
   parameter int CNT_W     = 6,
   parameter int CAPACITY  = 40
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic [NUM_LANES-1:0]        s_in,
   input  logic [NUM_LANES-1:0]        s_mid,
   input  logic [NUM_LANES-1:0]        s_exit,
   input  logic [2*NUM_LANES-1:0]      epass,
   input  logic                        lot_exit,
   output logic [NUM_LANES-1:0]        calc_req,
   output logic [TIME_W*NUM_LANES-1:0] transit_time,
   output logic [NUM_LANES-1:0]        gate_up,
   output logic [NUM_LANES-1:0]        reject,
   output logic [CNT_W-1:0]            occupancy,
   output logic                        lot_full
);
   localparam int SUM_W = CNT_W + 5;
   logic [NUM_LANES-1:0] busy, arrival, req, grant;
   logic [SUM_W-1:0] in_flight, arrivals, occ_add, occ_net;
   logic [CNT_W-1:0] occ_nx;
   logic exit_prev, departure;
   for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
      toll_lane_fsm #(.TIME_W(TIME_W), .TIMEOUT(TIMEOUT)) u_lane (
         .clk(clk),
         .reset_n(reset_n),
         .grant(grant[g]),
         .s_mid(s_mid[g]),
         .s_exit(s_exit[g]),
         .epass(epass[2*g +: 2]),
         .calc_req(calc_req[g]),
         .transit_time(transit_time[TIME_W*g +: TIME_W]),
         .gate_up(gate_up[g]),
         .reject(reject[g]),
         .arrival(arrival[g]),
         .busy(busy[g])
      );
   end
   assign departure = exit_prev && !lot_exit;
   assign lot_full  = SUM_W'(occupancy) + in_flight >= SUM_W'(CAPACITY);
   assign req       = s_in & ~busy;
   // lowest requesting index wins; nobody is admitted once space is fully reserved
   assign grant     = lot_full ? '0 : req & (~req + NUM_LANES'(1));
   always_comb begin
      in_flight = '0;
      arrivals  = '0;
      for (int i = 0; i < NUM_LANES; i++) begin
         in_flight = in_flight + SUM_W'(busy[i]);
         arrivals  = arrivals + SUM_W'(arrival[i]);
      end
      occ_add = SUM_W'(occupancy) + arrivals;
      occ_net = occ_add - SUM_W'(departure && occ_add != '0);
      occ_nx  = occ_net > SUM_W'(CAPACITY) ? CNT_W'(CAPACITY) : occ_net[CNT_W-1:0];
   end
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         occupancy <= '0;
         exit_prev <= 1'b0;
      end else begin
         occupancy <= occ_nx;
         exit_prev <= lot_exit;
      end
endmodule

// File: tb/tb_toll_gate_array_ctrl.sv
// tb_toll_gate_array_ctrl: directed scenarios on a default instance and a CAPACITY=2 instance sharing stimulus.
module tb_toll_gate_array_ctrl;
   localparam int TIMEOUT = 200;
   logic clk = 1'b0;
   logic reset_n;
   logic [1:0] s_in, s_mid, s_exit;
   logic [3:0] epass;
   logic lot_exit;
   logic [1:0] calc_req, gate_up, reject, calc_req_c, gate_up_c, reject_c;
   logic [15:0] transit_time, transit_time_c;
   logic [5:0] occupancy, occupancy_c;
   logic lot_full, lot_full_c;
   int checks = 0;
   int passes = 0;

   always #5 clk = ~clk;

   toll_gate_array_ctrl dut (
      .clk(clk), .reset_n(reset_n), .s_in(s_in), .s_mid(s_mid), .s_exit(s_exit), .epass(epass),
      .lot_exit(lot_exit), .calc_req(calc_req), .transit_time(transit_time), .gate_up(gate_up),
      .reject(reject), .occupancy(occupancy), .lot_full(lot_full)
   );

   toll_gate_array_ctrl #(.CAPACITY(2)) dut_c (
      .clk(clk), .reset_n(reset_n), .s_in(s_in), .s_mid(s_mid), .s_exit(s_exit), .epass(epass),
      .lot_exit(lot_exit), .calc_req(calc_req_c), .transit_time(transit_time_c), .gate_up(gate_up_c),
      .reject(reject_c), .occupancy(occupancy_c), .lot_full(lot_full_c)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      s_in = '0; s_mid = '0; s_exit = '0; epass = '0; lot_exit = 1'b0;
      tick();
      tick();
      reset_n = 1'b1;
      tick();
   endtask

   task automatic park_lane0();
      s_in = 2'b01; tick();
      s_in = 2'b00; s_mid = 2'b01; tick();
      s_mid = 2'b00; epass = 4'b0010; tick();
      epass = 4'b0000; s_exit = 2'b01; tick();
      s_exit = 2'b00; tick();
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (gate_up !== 2'b00) $display("FAIL reset_gate_up got=%b exp=00", gate_up); else passes++;
      checks++; if (calc_req !== 2'b00 || reject !== 2'b00) $display("FAIL reset_pulses got=%b/%b exp=00/00", calc_req, reject); else passes++;
      checks++; if (occupancy !== 6'd0 || lot_full !== 1'b0) $display("FAIL reset_occ got=%0d/%b exp=0/0", occupancy, lot_full); else passes++;
      checks++; if (transit_time !== 16'd0) $display("FAIL reset_transit got=%h exp=0000", transit_time); else passes++;
   endtask

   task automatic test_single_pass();
      s_in = 2'b01; tick();
      s_in = 2'b00;
      repeat (10) tick();
      s_mid = 2'b01; tick();
      checks++; if (transit_time[7:0] !== 8'd10) $display("FAIL pass_transit got=%0d exp=10", transit_time[7:0]); else passes++;
      checks++; if (calc_req !== 2'b01) $display("FAIL pass_calc_req got=%b exp=01", calc_req); else passes++;
      s_mid = 2'b00; tick();
      checks++; if (calc_req !== 2'b00) $display("FAIL pass_calc_pulse got=%b exp=00", calc_req); else passes++;
      checks++; if (gate_up !== 2'b00) $display("FAIL pass_gate_early got=%b exp=00", gate_up); else passes++;
      epass = 4'b0010; tick();
      checks++; if (gate_up !== 2'b01) $display("FAIL pass_gate_open got=%b exp=01", gate_up); else passes++;
      epass = 4'b0000; s_exit = 2'b01; tick();
      checks++; if (gate_up !== 2'b01) $display("FAIL pass_gate_hold got=%b exp=01", gate_up); else passes++;
      s_exit = 2'b00; tick();
      checks++; if (gate_up !== 2'b00) $display("FAIL pass_gate_close got=%b exp=00", gate_up); else passes++;
      checks++; if (occupancy !== 6'd1) $display("FAIL pass_occ got=%0d exp=1", occupancy); else passes++;
      checks++; if (transit_time[7:0] !== 8'd10) $display("FAIL pass_transit_held got=%0d exp=10", transit_time[7:0]); else passes++;
   endtask

   task automatic test_timeout();
      int early = 0;
      int opened = 0;
      s_in = 2'b10; tick();
      s_in = 2'b00; s_mid = 2'b10; tick();
      checks++; if (calc_req !== 2'b10) $display("FAIL to_calc_req got=%b exp=10", calc_req); else passes++;
      checks++; if (lot_full_c !== 1'b1) $display("FAIL to_reserved got=%b exp=1", lot_full_c); else passes++;
      s_mid = 2'b00; epass = 4'b0000;
      for (int k = 1; k < TIMEOUT; k++) begin
         tick();
         if (reject !== 2'b00) early++;
         if (gate_up[1] !== 1'b0) opened++;
      end
      checks++; if (early !== 0) $display("FAIL to_early_reject got=%0d exp=0", early); else passes++;
      tick();
      checks++; if (reject !== 2'b10) $display("FAIL to_reject got=%b exp=10", reject); else passes++;
      checks++; if (lot_full_c !== 1'b0) $display("FAIL to_released got=%b exp=0", lot_full_c); else passes++;
      tick();
      checks++; if (reject !== 2'b00) $display("FAIL to_reject_pulse got=%b exp=00", reject); else passes++;
      if (gate_up[1] !== 1'b0) opened++;
      checks++; if (opened !== 0) $display("FAIL to_gate_never got=%0d exp=0", opened); else passes++;
   endtask

   task automatic test_capacity();
      do_reset();
      park_lane0();
      checks++; if (occupancy_c !== 6'd1 || lot_full_c !== 1'b0) $display("FAIL cap_start got=%0d/%b exp=1/0", occupancy_c, lot_full_c); else passes++;
      s_in = 2'b11; tick();
      checks++; if (lot_full_c !== 1'b1) $display("FAIL cap_full got=%b exp=1", lot_full_c); else passes++;
      s_in = 2'b10; s_mid = 2'b01; tick();
      checks++; if (calc_req_c !== 2'b01) $display("FAIL cap_lane1_held got=%b exp=01", calc_req_c); else passes++;
      s_mid = 2'b00; epass = 4'b0001; tick();
      checks++; if (reject_c !== 2'b01 || lot_full_c !== 1'b0) $display("FAIL cap_reject got=%b/%b exp=01/0", reject_c, lot_full_c); else passes++;
      epass = 4'b0000; tick();
      checks++; if (lot_full_c !== 1'b1) $display("FAIL cap_lane1_admit got=%b exp=1", lot_full_c); else passes++;
      s_in = 2'b00; s_mid = 2'b10; tick();
      checks++; if (calc_req_c !== 2'b10) $display("FAIL cap_lane1_calc got=%b exp=10", calc_req_c); else passes++;
      s_mid = 2'b00;
   endtask

   task automatic test_net_occupancy();
      do_reset();
      repeat (5) park_lane0();
      checks++; if (occupancy !== 6'd5) $display("FAIL net_fill got=%0d exp=5", occupancy); else passes++;
      checks++; if (occupancy_c !== 6'd2) $display("FAIL net_cap_sat got=%0d exp=2", occupancy_c); else passes++;
      s_in = 2'b01; tick();
      s_in = 2'b00; s_mid = 2'b01; tick();
      s_mid = 2'b00; epass = 4'b0010; tick();
      epass = 4'b0000; s_exit = 2'b01; lot_exit = 1'b1; tick();
      s_exit = 2'b00; lot_exit = 1'b0; tick();
      checks++; if (occupancy !== 6'd5 || gate_up !== 2'b00) $display("FAIL net_same_cycle got=%0d/%b exp=5/00", occupancy, gate_up); else passes++;
      lot_exit = 1'b1; tick();
      lot_exit = 1'b0; tick();
      checks++; if (occupancy !== 6'd4) $display("FAIL net_departure got=%0d exp=4", occupancy); else passes++;
      do_reset();
      lot_exit = 1'b1; tick();
      lot_exit = 1'b0; tick();
      checks++; if (occupancy !== 6'd0) $display("FAIL net_empty got=%0d exp=0", occupancy); else passes++;
   endtask

   task automatic test_saturation();
      do_reset();
      s_in = 2'b01; tick();
      s_in = 2'b00;
      repeat (300) tick();
      s_mid = 2'b01; tick();
      checks++; if (transit_time[7:0] !== 8'd255) $display("FAIL sat_transit got=%0d exp=255", transit_time[7:0]); else passes++;
      s_mid = 2'b00; epass = 4'b0001; tick();
      epass = 4'b0000;
   endtask

   task automatic test_async_reset();
      do_reset();
      park_lane0();
      s_in = 2'b01; tick();
      s_in = 2'b00; s_mid = 2'b01; tick();
      s_mid = 2'b00; epass = 4'b0010; tick();
      epass = 4'b0000;
      checks++; if (gate_up !== 2'b01 || lot_full_c !== 1'b1) $display("FAIL ar_setup got=%b/%b exp=01/1", gate_up, lot_full_c); else passes++;
      #2 reset_n = 1'b0;
      #1;
      checks++; if (gate_up !== 2'b00) $display("FAIL ar_gate_async got=%b exp=00", gate_up); else passes++;
      checks++; if (occupancy !== 6'd0 || occupancy_c !== 6'd0) $display("FAIL ar_occ got=%0d/%0d exp=0/0", occupancy, occupancy_c); else passes++;
      tick();
      reset_n = 1'b1;
      tick();
      checks++; if (lot_full_c !== 1'b0 || gate_up !== 2'b00) $display("FAIL ar_idle got=%b/%b exp=0/00", lot_full_c, gate_up); else passes++;
   endtask

   initial begin
      test_reset();
      test_single_pass();
      test_timeout();
      test_capacity();
      test_net_occupancy();
      test_saturation();
      test_async_reset();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end
endmodule
